// File: rtl/sig_period_meter.sv
// Measures the period and high time of a slow asynchronous square wave in clk cycles,
// with a sticky timeout when rising edges stop arriving.
module sig_period_meter #(
  parameter logic [31:0] TIMEOUT = 32'd10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        sp_q, sp_d;
  logic [1:0]  fill_q, fill_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hcnt_q, hcnt_d;
  logic [31:0] hlat_q, hlat_d;
  logic [31:0] period_q, period_d;
  logic [31:0] high_time_q, high_time_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  logic rise;
  logic fall;

  assign rise = s2_q & ~sp_q;
  assign fall = ~s2_q & sp_q;

  always_comb begin
    state_d     = state_q;
    s1_d        = sig_in;
    s2_d        = s1_q;
    sp_d        = s2_q;
    fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    hlat_d      = hlat_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      IDLE: begin
        // The synchronizer holds reset zeros for two cycles; only a genuinely sampled
        // low level may arm the meter, otherwise a level held high through reset
        // would look like a fresh rising edge.
        if (!s2_q && fill_q == 2'd2) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (rise) begin
          cnt_d   = 32'd1;
          hcnt_d  = 32'd1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        cnt_d  = cnt_q + 32'd1;
        hcnt_d = hcnt_q + 32'd1;
        if (cnt_q == TIMEOUT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (fall) begin
          hlat_d  = hcnt_q;
          state_d = LOW;
        end
      end
      LOW: begin
        cnt_d = cnt_q + 32'd1;
        // A rise landing exactly on the timeout count is still a good measurement.
        if (rise) begin
          period_d    = cnt_q;
          high_time_d = hlat_q;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          cnt_d       = 32'd1;
          hcnt_d      = 32'd1;
          state_d     = HIGH;
        end else if (cnt_q == TIMEOUT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      sp_q        <= 1'b0;
      fill_q      <= 2'd0;
      cnt_q       <= 32'd0;
      hcnt_q      <= 32'd0;
      hlat_q      <= 32'd0;
      period_q    <= 32'd0;
      high_time_q <= 32'd0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      sp_q        <= sp_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      hlat_q      <= hlat_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_sig_period_meter.sv
// Bench for sig_period_meter: timestamp-based reference model of rises/falls on the
// sampled input, per-cycle output comparison, and a few directed literal checks.
module tb_sig_period_meter;

  localparam int TO   = 40;
  localparam int MAXE = 30000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        timeout;

  sig_period_meter #(.TIMEOUT(32'(TO))) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(period), .high_time(high_time), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model: samp[k] is the level captured at clk edge k. Outputs driven at
  // edge k reflect the sampled level at edge k-2 (two synchronizer stages).
  bit samp [0:MAXE];
  int edge_n    = 0;
  int idle_from = 0;
  int mode      = 0;   // 0 waiting for a real low, 1 armed, 2 measuring
  int t_rise    = 0;
  int t_fall    = 0;
  bit have_fall = 1'b0;
  bit          exp_valid   = 1'b0;
  logic [31:0] exp_period  = '0;
  logic [31:0] exp_high    = '0;
  bit          exp_timeout = 1'b0;

  always @(posedge clk) begin
    int j, d;
    bit r, f;
    if (edge_n <= MAXE) samp[edge_n] = sig_in;
    exp_valid = 1'b0;
    if (rst) begin
      mode        = 0;
      idle_from   = edge_n + 1;
      exp_period  = '0;
      exp_high    = '0;
      exp_timeout = 1'b0;
    end else begin
      j = edge_n - 2;
      if (j >= idle_from && j >= 1 && j <= MAXE) begin
        r = samp[j] && !samp[j-1];
        f = !samp[j] && samp[j-1];
        case (mode)
          0: if (!samp[j]) mode = 1;
          1: if (r) begin
               mode = 2; t_rise = j; have_fall = 1'b0;
             end
          default: begin
            d = j - t_rise;
            if (r) begin
              exp_period  = 32'(d);
              exp_high    = 32'(t_fall - t_rise);
              exp_valid   = 1'b1;
              exp_timeout = 1'b0;
              t_rise      = j;
              have_fall   = 1'b0;
            end else if (d == TO) begin
              exp_timeout = 1'b1;
              mode        = 0;
              idle_from   = j + 1;
            end else if (f && !have_fall) begin
              t_fall    = j;
              have_fall = 1'b1;
            end
          end
        endcase
      end
    end
    edge_n++;
  end

  bit          lit_on = 1'b0;
  logic [31:0] lit_p  = '0;
  logic [31:0] lit_h  = '0;
  int          valid_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (valid !== exp_valid || period !== exp_period ||
          high_time !== exp_high || timeout !== exp_timeout)
        $display("FAIL model t=%0t: got v=%0b p=%0d h=%0d to=%0b, need v=%0b p=%0d h=%0d to=%0b",
                 $time, valid, period, high_time, timeout,
                 exp_valid, exp_period, exp_high, exp_timeout);
      else
        n_pass++;
      if (valid === 1'b1) begin
        valid_cnt++;
        if (lit_on) begin
          n_checks++;
          if (period !== lit_p || high_time !== lit_h)
            $display("FAIL literal t=%0t: got p=%0d h=%0d, need p=%0d h=%0d",
                     $time, period, high_time, lit_p, lit_h);
          else
            n_pass++;
        end
      end
    end
  end

  task automatic hold(input bit lvl, input int n);
    sig_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    valid_cnt = 0;
  endtask

  task automatic lit_check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) $display("FAIL %s: got %0d, need %0d", name, act, req);
    else n_pass++;
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;

    // Level held high through reset, then low 4 / high 6.
    sig_in = 1'b1;
    do_reset(3);
    lit_p = 10; lit_h = 6; lit_on = 1'b1;
    hold(1, 5);
    repeat (3) begin hold(0, 4); hold(1, 6); end
    hold(0, 4); hold(1, 4);
    lit_on = 1'b0;
    lit_check("valids_high_through_reset", valid_cnt, 3);

    // High 5 / low 3.
    sig_in = 1'b0;
    do_reset(1);
    lit_p = 8; lit_h = 5; lit_on = 1'b1;
    hold(0, 2);
    repeat (5) begin hold(1, 5); hold(0, 3); end
    hold(1, 4);
    lit_on = 1'b0;
    lit_check("valids_5_3", valid_cnt, 5);

    // Rises exactly TIMEOUT cycles apart.
    do_reset(1);
    lit_p = 32'(TO); lit_h = 10; lit_on = 1'b1;
    hold(0, 2);
    repeat (4) begin hold(1, 10); hold(0, TO - 10); end
    hold(1, 4);
    lit_on = 1'b0;
    lit_check("valids_at_timeout_edge", valid_cnt, 4);
    lit_check("no_timeout_at_edge", int'(timeout), 0);

    // Single rise then held low: timeout, then recovery after two rises.
    do_reset(1);
    hold(0, 2); hold(1, 10); hold(0, 60);
    lit_check("timeout_set", int'(timeout), 1);
    lit_check("timeout_no_valid", valid_cnt, 0);
    lit_check("timeout_holds_period", int'(period), 0);
    lit_p = 10; lit_h = 5; lit_on = 1'b1;
    hold(1, 5); hold(0, 5); hold(1, 5); hold(0, 2);
    lit_on = 1'b0;
    lit_check("recovery_valid", valid_cnt, 1);
    lit_check("timeout_cleared", int'(timeout), 0);

    // Reset pulse in the middle of a high phase.
    do_reset(1);
    hold(0, 2); hold(1, 6); hold(0, 4); hold(1, 6); hold(0, 4); hold(1, 3);
    do_reset(1);
    lit_check("reset_mid_high_period", int'(period), 0);
    hold(1, 3); hold(0, 4); hold(1, 6); hold(0, 4); hold(1, 3);

    // Randomized levels and durations, with occasional resets.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      hold(~sig_in, $urandom_range(1, 50));
    end
    hold(0, 5);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
